// File: rtl/pe_stim_tx.sv
// Stimulus transmitter for PE-array benches: emits ramp, LFSR or replayed
// multi-lane words over a valid/ready port with programmable gaps and count.
module pe_stim_tx #(
    parameter int NUM_LANES = 8,
    parameter int LANE_W    = 16,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 16,
    parameter int GAP_W     = 8,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int WORD_W   = NUM_LANES * LANE_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [GAP_W-1:0]  gap,
    input  logic [31:0]       seed,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ovalid,
    input  logic              oready,
    output logic [WORD_W-1:0] odata,
    output logic              olast,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [1:0] MODE_LFSR   = 2'd1;
    localparam logic [1:0] MODE_REPLAY = 2'd2;

    // Handshake: a word transfers on a rising edge where ovalid and oready are
    // both high; odata/olast stay frozen while ovalid is high and oready is low.

    logic [1:0]        r_state;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_num;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [31:0]       r_lfsr;
    logic              r_ovalid;
    logic [WORD_W-1:0] r_odata;
    logic              r_olast;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_sent;
    logic [WORD_W-1:0] r_buf [DEPTH];

    logic [1:0]        w_gen_mode;
    logic [CNT_W-1:0]  w_gen_idx;
    logic [31:0]       w_gen_lfsr;
    logic [31:0]       w_seed_fix;
    logic [31:0]       w_lfsr_next;
    logic [WORD_W-1:0] w_gen_word;
    logic              w_is_last;

    function automatic logic [31:0] rotl32(input logic [31:0] s, input int r);
        return (s << r) | (s >> (32 - r));
    endfunction

    assign w_seed_fix  = (seed == 32'd0) ? 32'd1 : seed;
    assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_is_last   = (r_idx == r_num - CNT_W'(1));

    // In IDLE the generator builds word 0 from the live config; otherwise it
    // builds the word after the one currently on the port.
    always_comb begin
        w_gen_mode = r_mode;
        w_gen_idx  = r_idx + CNT_W'(1);
        w_gen_lfsr = w_lfsr_next;
        if (r_state == ST_IDLE) begin
            w_gen_mode = mode;
            w_gen_idx  = '0;
            w_gen_lfsr = w_seed_fix;
        end
    end

    always_comb begin
        w_gen_word = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            case (w_gen_mode)
                MODE_LFSR:
                    w_gen_word[l*LANE_W +: LANE_W] = LANE_W'(rotl32(w_gen_lfsr, l % 32));
                MODE_REPLAY:
                    w_gen_word[l*LANE_W +: LANE_W] = r_buf[w_gen_idx[ADDR_W-1:0]][l*LANE_W +: LANE_W];
                default:
                    w_gen_word[l*LANE_W +: LANE_W] =
                        LANE_W'(32'(w_gen_idx) * 32'(NUM_LANES) + 32'(l));
            endcase
        end
    end

    // Replay storage has no reset; contents persist across runs.
    always_ff @(posedge clock) begin
        if (ld_en && !r_busy) begin
            r_buf[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_mode    <= 2'd0;
            r_num     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_lfsr    <= 32'd1;
            r_ovalid  <= 1'b0;
            r_odata   <= '0;
            r_olast   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sent    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_num  <= num_words;
                        r_gap  <= gap;
                        r_sent <= '0;
                        r_idx  <= '0;
                        r_lfsr <= w_seed_fix;
                        r_busy <= 1'b1;
                        if (num_words != '0) begin
                            r_state  <= ST_SEND;
                            r_ovalid <= 1'b1;
                            r_odata  <= w_gen_word;
                            r_olast  <= (num_words == CNT_W'(1));
                        end else begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (oready) begin
                        r_sent <= r_sent + CNT_W'(1);
                        if (w_is_last) begin
                            r_state  <= ST_FIN;
                            r_ovalid <= 1'b0;
                            r_olast  <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx   <= w_gen_idx;
                            r_lfsr  <= w_lfsr_next;
                            r_odata <= w_gen_word;
                            r_olast <= (w_gen_idx == r_num - CNT_W'(1));
                            if (r_gap != '0) begin
                                r_state   <= ST_GAP;
                                r_ovalid  <= 1'b0;
                                r_gap_cnt <= r_gap;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_state  <= ST_SEND;
                        r_ovalid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ovalid    = r_ovalid;
    assign odata     = r_odata;
    assign olast     = r_olast;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sent      = r_sent;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pe_stim_tx.sv
// Directed bench for pe_stim_tx: ramp, backpressure, LFSR with gaps, replay
// wrap, zero-length and ignored starts, and asynchronous reset mid-run.
module tb_pe_stim_tx;

    localparam int NL    = 8;
    localparam int LW    = 16;
    localparam int DEPTH = 64;
    localparam int CNT_W = 16;
    localparam int GAP_W = 8;
    localparam int AW    = 6;
    localparam int W     = NL * LW;

    logic             clock     = 1'b0;
    logic             resetn    = 1'b0;
    logic             start     = 1'b0;
    logic [1:0]       mode      = 2'd0;
    logic [CNT_W-1:0] num_words = '0;
    logic [GAP_W-1:0] gap       = '0;
    logic [31:0]      seed      = '0;
    logic             ld_en     = 1'b0;
    logic [AW-1:0]    ld_addr   = '0;
    logic [W-1:0]     ld_data   = '0;
    logic             oready    = 1'b0;
    logic             ovalid;
    logic [W-1:0]     odata;
    logic             olast;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    pe_stim_tx #(
        .NUM_LANES(NL), .LANE_W(LW), .DEPTH(DEPTH), .CNT_W(CNT_W), .GAP_W(GAP_W)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .mode(mode),
        .num_words(num_words), .gap(gap), .seed(seed), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .ovalid(ovalid), .oready(oready),
        .odata(odata), .olast(olast), .busy(busy), .done(done), .sent(sent),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ramp_word(input int n);
        logic [W-1:0] w;
        for (int l = 0; l < NL; l++) w[l*LW +: LW] = LW'(n * NL + l);
        return w;
    endfunction

    function automatic logic [W-1:0] rep_word(input int v);
        logic [W-1:0] w;
        for (int l = 0; l < NL; l++) w[l*LW +: LW] = LW'(v);
        return w;
    endfunction

    // Start pulse is presented for one rising edge; returns at the falling
    // edge right after it, when word 0 should already be on the port.
    task automatic do_start(input logic [1:0] m, input int n, input int g, input logic [31:0] s);
        @(negedge clock);
        mode      = m;
        num_words = CNT_W'(n);
        gap       = GAP_W'(g);
        seed      = s;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (ovalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || olast !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b b=%b d=%b l=%b exp 0000", ovalid, busy, done, olast);
        end
        checks++;
        if (odata !== '0 || sent !== '0) begin
            failures++;
            $display("FAIL reset_data got odata=%h sent=%0d exp 0/0", odata, sent);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got %0d exp 0", dbg_state);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ramp;
        logic [15:0] lane0 [4];
        lane0[0] = 16'd0; lane0[1] = 16'd8; lane0[2] = 16'd16; lane0[3] = 16'd24;
        oready = 1'b1;
        do_start(2'd0, 4, 0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ovalid !== 1'b1 || odata !== ramp_word(i) || odata[15:0] !== lane0[i]) begin
                failures++;
                $display("FAIL ramp_word%0d got v=%b %h exp 1 %h", i, ovalid, odata, ramp_word(i));
            end
            checks++;
            if (olast !== (i == 3) || busy !== 1'b1) begin
                failures++;
                $display("FAIL ramp_last%0d got last=%b busy=%b exp %b 1", i, olast, busy, i == 3);
            end
            @(negedge clock);
        end
        checks++;
        if (ovalid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ramp_done got v=%b d=%b b=%b exp 0 1 1", ovalid, done, busy);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sent !== CNT_W'(4)) begin
            failures++;
            $display("FAIL ramp_end got b=%b d=%b sent=%0d exp 0 0 4", busy, done, sent);
        end
    endtask

    task automatic test_backpressure;
        int           acc = 0;
        logic [W-1:0] held = '0;
        logic         held_v = 1'b0;
        logic [W-1:0] w2 = '0;
        logic         seen_done = 1'b0;
        oready = 1'b0;
        do_start(2'd0, 3, 0, 32'd0);
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (done) seen_done = 1'b1;
            if (ovalid) begin
                if (held_v) begin
                    checks++;
                    if (odata !== held) begin
                        failures++;
                        $display("FAIL bp_hold got %h exp %h", odata, held);
                    end
                end
                checks++;
                if (odata !== ramp_word(acc) || olast !== (acc == 2)) begin
                    failures++;
                    $display("FAIL bp_word%0d got %h last=%b exp %h %b", acc, odata, olast, ramp_word(acc), acc == 2);
                end
            end
            oready = (c % 3 == 0);
            if (ovalid && oready) begin
                if (acc == 2) w2 = odata;
                acc++;
                held_v = 1'b0;
            end else if (ovalid) begin
                held   = odata;
                held_v = 1'b1;
            end
            @(negedge clock);
        end
        checks++;
        if (!seen_done || acc != 3 || sent !== CNT_W'(3)) begin
            failures++;
            $display("FAIL bp_count got done=%b acc=%0d sent=%0d exp 1 3 3", seen_done, acc, sent);
        end
        checks++;
        if (w2[7*LW +: LW] !== 16'd23) begin
            failures++;
            $display("FAIL bp_w2_lane7 got %0d exp 23", w2[7*LW +: LW]);
        end
        oready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_gap_lfsr;
        logic [W-1:0] w0, w1;
        w0 = {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001};
        w1 = {16'h0180, 16'h00C0, 16'h0060, 16'h0030, 16'h0018, 16'h000C, 16'h0006, 16'h0003};
        oready = 1'b1;
        do_start(2'd1, 2, 3, 32'd0);
        checks++;
        if (ovalid !== 1'b1 || odata !== w0 || odata[15:0] !== 16'h0001) begin
            failures++;
            $display("FAIL lfsr_w0 got v=%b %h exp 1 %h", ovalid, odata, w0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (ovalid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL gap_idle%0d got v=%b b=%b exp 0 1", i, ovalid, busy);
            end
        end
        @(negedge clock);
        checks++;
        if (ovalid !== 1'b1 || odata !== w1 || olast !== 1'b1) begin
            failures++;
            $display("FAIL lfsr_w1 got v=%b %h l=%b exp 1 %h 1", ovalid, odata, olast, w1);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL gap_done got %b exp 1", done);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || sent !== CNT_W'(2)) begin
            failures++;
            $display("FAIL gap_end got b=%b sent=%0d exp 0 2", busy, sent);
        end
    endtask

    task automatic test_lfsr_taps;
        logic [31:0]  seeds [3];
        logic [W-1:0] w0s [3];
        logic [W-1:0] w1s [3];
        seeds[0] = 32'h8000_0000;
        w0s[0]   = {16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000};
        w1s[0]   = {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001};
        seeds[1] = 32'h0020_0000;
        w0s[1]   = '0;
        w1s[1]   = {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001};
        seeds[2] = 32'h0000_0002;
        w0s[2]   = {16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002};
        w1s[2]   = {16'h0280, 16'h0140, 16'h00A0, 16'h0050, 16'h0028, 16'h0014, 16'h000A, 16'h0005};
        oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_start(2'd1, 2, 0, seeds[i]);
            checks++;
            if (ovalid !== 1'b1 || odata !== w0s[i]) begin
                failures++;
                $display("FAIL taps%0d_w0 got v=%b %h exp 1 %h", i, ovalid, odata, w0s[i]);
            end
            @(negedge clock);
            checks++;
            if (ovalid !== 1'b1 || odata !== w1s[i]) begin
                failures++;
                $display("FAIL taps%0d_w1 got v=%b %h exp 1 %h", i, ovalid, odata, w1s[i]);
            end
            repeat (2) @(negedge clock);
        end
    endtask

    task automatic test_replay;
        int           idx = 0;
        logic         seen_done = 1'b0;
        logic [W-1:0] exp_w;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clock);
            ld_en   = 1'b1;
            ld_addr = AW'(k);
            ld_data = rep_word(k);
        end
        @(negedge clock);
        ld_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 70; i++) exp_q.push_back(rep_word(i % DEPTH));
        oready = 1'b1;
        do_start(2'd2, 70, 0, 32'd0);
        for (int c = 0; c < 100 && !seen_done; c++) begin
            if (done) seen_done = 1'b1;
            if (ovalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL replay_extra got %h exp no word", odata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (odata !== exp_w || olast !== (idx == 69)) begin
                        failures++;
                        $display("FAIL replay_word%0d got %h l=%b exp %h %b", idx, odata, olast, exp_w, idx == 69);
                    end
                end
                idx++;
            end
            // Buffer writes attempted throughout the run must be dropped.
            ld_en   = ovalid && !olast;
            ld_addr = AW'(idx);
            ld_data = rep_word(16'hDEAD);
            @(negedge clock);
        end
        ld_en = 1'b0;
        checks++;
        if (!seen_done || exp_q.size() != 0 || sent !== CNT_W'(70)) begin
            failures++;
            $display("FAIL replay_count got done=%b left=%0d sent=%0d exp 1 0 70", seen_done, exp_q.size(), sent);
        end
        @(negedge clock);
        do_start(2'd2, 1, 0, 32'd0);
        checks++;
        if (ovalid !== 1'b1 || odata !== rep_word(0) || olast !== 1'b1) begin
            failures++;
            $display("FAIL replay_keep got v=%b %h l=%b exp 1 %h 1", ovalid, odata, olast, rep_word(0));
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_zero_and_busy;
        oready = 1'b1;
        do_start(2'd0, 0, 0, 32'd0);
        checks++;
        if (ovalid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || sent !== '0) begin
            failures++;
            $display("FAIL zero_done got v=%b d=%b b=%b sent=%0d exp 0 1 1 0", ovalid, done, busy, sent);
        end
        @(negedge clock);
        checks++;
        if (ovalid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_end got v=%b d=%b b=%b exp 0 0 0", ovalid, done, busy);
        end
        do_start(2'd3, 2, 2, 32'd0);
        checks++;
        if (ovalid !== 1'b1 || odata !== ramp_word(0)) begin
            failures++;
            $display("FAIL m3_w0 got v=%b %h exp 1 %h", ovalid, odata, ramp_word(0));
        end
        @(negedge clock);
        mode      = 2'd1;
        num_words = CNT_W'(9);
        gap       = '0;
        seed      = 32'd5;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (ovalid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_gap got v=%b b=%b exp 0 1", ovalid, busy);
        end
        @(negedge clock);
        checks++;
        if (ovalid !== 1'b1 || odata !== ramp_word(1) || olast !== 1'b1) begin
            failures++;
            $display("FAIL busy_w1 got v=%b %h l=%b exp 1 %h 1", ovalid, odata, olast, ramp_word(1));
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL busy_done got %b exp 1", done);
        end
        mode      = 2'd0;
        num_words = CNT_W'(3);
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || ovalid !== 1'b0 || sent !== CNT_W'(2)) begin
            failures++;
            $display("FAIL done_start got b=%b v=%b sent=%0d exp 0 0 2", busy, ovalid, sent);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || ovalid !== 1'b0) begin
            failures++;
            $display("FAIL done_start2 got b=%b v=%b exp 0 0", busy, ovalid);
        end
    endtask

    task automatic test_reset_midrun;
        oready = 1'b1;
        do_start(2'd0, 5, 0, 32'd0);
        @(negedge clock);
        @(negedge clock);
        oready = 1'b0;
        checks++;
        if (sent !== CNT_W'(2) || odata !== ramp_word(2)) begin
            failures++;
            $display("FAIL mid_pre got sent=%0d %h exp 2 %h", sent, odata, ramp_word(2));
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (ovalid !== 1'b0 || busy !== 1'b0 || sent !== '0 || odata !== '0 || olast !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got v=%b b=%b sent=%0d %h l=%b exp zeros", ovalid, busy, sent, odata, olast);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || ovalid !== 1'b0) begin
                failures++;
                $display("FAIL mid_nodone%0d got d=%b v=%b exp 0 0", i, done, ovalid);
            end
        end
        oready = 1'b1;
        do_start(2'd0, 2, 0, 32'd0);
        checks++;
        if (ovalid !== 1'b1 || odata !== ramp_word(0) || sent !== '0) begin
            failures++;
            $display("FAIL mid_restart got v=%b %h sent=%0d exp 1 %h 0", ovalid, odata, sent, ramp_word(0));
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || sent !== CNT_W'(2)) begin
            failures++;
            $display("FAIL mid_end got b=%b sent=%0d exp 0 2", busy, sent);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_gap_lfsr();
        test_lfsr_taps();
        test_replay();
        test_zero_and_busy();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got timeout exp completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
